// File: rtl/uart_port_controller.sv
// Serial-port side of the MEM stage: drives the UART rdn/wrn strobes, moves bytes over the
// RAM1 data bus low byte, and reports rx/tx readiness and busy for pipeline stalls.
module uart_port_controller #(
  parameter int unsigned RD_PULSE = 2,
  parameter int unsigned WR_PULSE = 2,
  parameter int unsigned TIMEOUT  = 16'hFFFF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [15:0] wr_data,
  output logic [15:0] rd_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        status_rx_ready,
  output logic        status_tx_ready,
  input  logic        data_ready,
  input  logic        tbre,
  input  logic        tsre,
  output logic        rdn,
  output logic        wrn,
  input  logic [7:0]  bus_in,
  output logic [7:0]  bus_out,
  output logic        bus_oe
);

  typedef enum logic [3:0] {
    StIdle,
    StRdWait,
    StRdLow,
    StWrSetup,
    StWrLow,
    StWrHold,
    StWrWaitTbre,
    StWrWaitTsre,
    StDone
  } state_e;

  localparam logic [7:0]  RdLast  = 8'(RD_PULSE - 1);
  localparam logic [7:0]  WrLast  = 8'(WR_PULSE - 1);
  localparam logic [15:0] TmoLast = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [1:0]  dr_sync_q, tbre_sync_q, tsre_sync_q;
  logic        data_ready_s, tbre_s, tsre_s;
  logic [7:0]  pulse_q, pulse_d;
  logic [15:0] tmo_q, tmo_d;
  logic        tmo_hit;
  logic [7:0]  wr_byte_q;
  logic [15:0] rd_data_q;
  logic        err_q;
  logic        unused_wr_hi;

  assign unused_wr_hi = ^wr_data[15:8];

  // Two-flop synchronizers for the asynchronous UART status pins.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      dr_sync_q   <= '0;
      tbre_sync_q <= '0;
      tsre_sync_q <= '0;
    end else begin
      dr_sync_q   <= {dr_sync_q[0], data_ready};
      tbre_sync_q <= {tbre_sync_q[0], tbre};
      tsre_sync_q <= {tsre_sync_q[0], tsre};
    end
  end

  assign data_ready_s = dr_sync_q[1];
  assign tbre_s       = tbre_sync_q[1];
  assign tsre_s       = tsre_sync_q[1];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tmo_hit = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_write) begin
          state_d = StWrSetup;
        end else if (req_read) begin
          state_d = StRdWait;
        end
      end
      StRdWait: begin
        if (data_ready_s) begin
          state_d = StRdLow;
        end else if (tmo_q == TmoLast) begin
          state_d = StDone;
          tmo_hit = 1'b1;
        end
      end
      StRdLow:   if (pulse_q == RdLast) state_d = StDone;
      StWrSetup: state_d = StWrLow;
      StWrLow:   if (pulse_q == WrLast) state_d = StWrHold;
      StWrHold:  state_d = StWrWaitTbre;
      StWrWaitTbre: begin
        if (tbre_s) begin
          state_d = StWrWaitTsre;
        end else if (tmo_q == TmoLast) begin
          state_d = StDone;
          tmo_hit = 1'b1;
        end
      end
      StWrWaitTsre: begin
        if (tsre_s) begin
          state_d = StDone;
        end else if (tmo_q == TmoLast) begin
          state_d = StDone;
          tmo_hit = 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Both counters restart whenever the state changes, so each state sees 0 on entry.
  always_comb begin
    pulse_d = '0;
    tmo_d   = '0;
    if (state_d == state_q && state_q != StIdle) begin
      pulse_d = pulse_q + 8'd1;
      tmo_d   = tmo_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pulse_q   <= '0;
      tmo_q     <= '0;
      wr_byte_q <= '0;
      rd_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      pulse_q <= pulse_d;
      tmo_q   <= tmo_d;
      err_q   <= tmo_hit;
      if (state_q == StIdle && req_write) begin
        wr_byte_q <= wr_data[7:0];
      end
      if (state_q == StRdLow && pulse_q == RdLast) begin
        rd_data_q <= {8'h00, bus_in};
      end
    end
  end

  always_comb begin
    rdn    = 1'b1;
    wrn    = 1'b1;
    bus_oe = 1'b0;
    busy   = (state_q != StIdle);
    done   = (state_q == StDone);
    unique case (state_q)
      StRdLow:            rdn = 1'b0;
      StWrSetup, StWrHold: bus_oe = 1'b1;
      StWrLow: begin
        wrn    = 1'b0;
        bus_oe = 1'b1;
      end
      default: ;
    endcase
  end

  assign err             = err_q;
  assign rd_data         = rd_data_q;
  assign bus_out         = wr_byte_q;
  assign status_rx_ready = data_ready_s;
  assign status_tx_ready = (state_q == StIdle) && tbre_s && tsre_s;

endmodule

// File: tb/tb_uart_port_controller.sv
// Randomized bench: a cycle-timeline model predicts strobes and completions; a monitor checks
// per-cycle pin behaviour and pops a scoreboard queue whenever done pulses.
module tb_uart_port_controller;
  localparam int unsigned RdPulse = 2;
  localparam int unsigned WrPulse = 2;
  localparam int unsigned Tmo     = 16;
  localparam int          MaxCyc  = 4096;

  logic        CLK, RST;
  logic        req_read, req_write;
  logic [15:0] wr_data, rd_data;
  logic        busy, done, err, status_rx_ready, status_tx_ready;
  logic        data_ready, tbre, tsre, rdn, wrn, bus_oe;
  logic [7:0]  bus_in, bus_out;

  uart_port_controller #(
    .RD_PULSE(RdPulse),
    .WR_PULSE(WrPulse),
    .TIMEOUT (Tmo)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .req_read       (req_read),
    .req_write      (req_write),
    .wr_data        (wr_data),
    .rd_data        (rd_data),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .status_rx_ready(status_rx_ready),
    .status_tx_ready(status_tx_ready),
    .data_ready     (data_ready),
    .tbre           (tbre),
    .tsre           (tsre),
    .rdn            (rdn),
    .wrn            (wrn),
    .bus_in         (bus_in),
    .bus_out        (bus_out),
    .bus_oe         (bus_oe)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Stimulus plan per cycle and expected pin timeline per cycle.
  bit          dr_p[MaxCyc], tbre_p[MaxCyc], tsre_p[MaxCyc], rr_p[MaxCyc], rw_p[MaxCyc];
  logic [15:0] wd_p[MaxCyc];
  logic [7:0]  bi_p[MaxCyc];
  bit          e_busy[MaxCyc], e_rdl[MaxCyc], e_wrl[MaxCyc], e_oe[MaxCyc];
  logic [7:0]  e_byte[MaxCyc];

  typedef struct {
    int          cyc;
    bit          err;
    logic [15:0] rd;
  } exp_t;
  exp_t sbq[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int end_cyc  = 0;
  bit run_mon  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // First cycle in [from,to] whose synchronized pin is high (pin value two cycles earlier).
  function automatic int first_hi(input int sel, input int from, input int to);
    for (int c = from; c <= to; c++) begin
      if ((sel == 0 && dr_p[c-2]) || (sel == 1 && tbre_p[c-2]) || (sel == 2 && tsre_p[c-2]))
        return c;
    end
    return -1;
  endfunction

  task automatic apply(input int c);
    req_read   = rr_p[c];
    req_write  = rw_p[c];
    wr_data    = wd_p[c];
    bus_in     = bi_p[c];
    data_ready = dr_p[c];
    tbre       = tbre_p[c];
    tsre       = tsre_p[c];
  endtask

  task automatic build_plan();
    int          k, n, ed, w, t, s, t0, rdr, rt, rs;
    bit          is_wr, e_err;
    logic [15:0] last_rd, rd;
    logic [7:0]  byte_v;
    for (int c = 0; c < MaxCyc; c++) begin
      wd_p[c]   = 16'($urandom);
      bi_p[c]   = 8'($urandom);
      dr_p[c]   = 1'($urandom);
      tbre_p[c] = 1'($urandom);
      tsre_p[c] = 1'($urandom);
    end
    k = 4;
    n = 0;
    last_rd = 16'h0000;
    while (k < MaxCyc - 200 && n < 60) begin
      is_wr = (n == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      rdr = (n == 2) ? 40 : int'($urandom_range(0, Tmo + 8));
      rt  = int'($urandom_range(0, Tmo + 14));
      rs  = int'($urandom_range(0, Tmo + 26));
      for (int c = k - 2; c <= k + 100; c++) begin
        dr_p[c]   = (c >= k - 2 + rdr);
        tbre_p[c] = (c >= k - 2 + rt);
        tsre_p[c] = (c >= k - 2 + rs);
      end
      if (is_wr) begin
        rw_p[k] = 1'b1;
        if ($urandom_range(0, 4) == 0) rr_p[k] = 1'b1;
      end else begin
        rr_p[k] = 1'b1;
      end
      // Requests while busy must be dropped.
      if ($urandom_range(0, 3) == 0) rr_p[k+2] = 1'b1;
      if ($urandom_range(0, 3) == 0) rw_p[k+3] = 1'b1;
      rd = last_rd;
      e_err = 1'b0;
      if (!is_wr) begin
        w = first_hi(0, k + 1, k + int'(Tmo));
        if (w >= 0) begin
          ed = w + 1 + int'(RdPulse);
          for (int c = w + 1; c <= w + int'(RdPulse); c++) e_rdl[c] = 1'b1;
          rd = {8'h00, bi_p[w + int'(RdPulse)]};
          last_rd = rd;
        end else begin
          ed = k + 1 + int'(Tmo);
          e_err = 1'b1;
        end
      end else begin
        byte_v = wd_p[k][7:0];
        for (int c = k + 1; c <= k + 2 + int'(WrPulse); c++) begin
          e_oe[c]   = 1'b1;
          e_byte[c] = byte_v;
        end
        for (int c = k + 2; c <= k + 1 + int'(WrPulse); c++) e_wrl[c] = 1'b1;
        t0 = k + 3 + int'(WrPulse);
        t = first_hi(1, t0, t0 + int'(Tmo) - 1);
        if (t < 0) begin
          ed = t0 + int'(Tmo);
          e_err = 1'b1;
        end else begin
          s = first_hi(2, t + 1, t + int'(Tmo));
          if (s < 0) begin
            ed = t + 1 + int'(Tmo);
            e_err = 1'b1;
          end else begin
            ed = s + 1;
          end
        end
      end
      for (int c = k + 1; c <= ed; c++) e_busy[c] = 1'b1;
      sbq.push_back('{cyc: ed, err: e_err, rd: rd});
      k = ed + 3 + int'($urandom_range(0, 3));
      n++;
    end
    end_cyc = k;
  endtask

  always @(negedge CLK) begin
    if (run_mon) begin
      exp_t e;
      chk("busy", 32'(busy), 32'(e_busy[cyc]));
      chk("rdn", 32'(rdn), 32'(!e_rdl[cyc]));
      chk("wrn", 32'(wrn), 32'(!e_wrl[cyc]));
      chk("bus_oe", 32'(bus_oe), 32'(e_oe[cyc]));
      if (e_oe[cyc]) chk("bus_out", 32'(bus_out), 32'(e_byte[cyc]));
      if (!rdn) chk("oe_during_rdn", 32'(bus_oe), 32'(0));
      if (cyc >= 2) begin
        chk("rx_ready", 32'(status_rx_ready), 32'(dr_p[cyc-2]));
        chk("tx_ready", 32'(status_tx_ready),
            32'(!e_busy[cyc] && tbre_p[cyc-2] && tsre_p[cyc-2]));
      end
      while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
        checks++;
        failures++;
        $display("FAIL done_missing cyc=%0d got=none expected_done_at=%0d", cyc, sbq[0].cyc);
        void'(sbq.pop_front());
      end
      if (done) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL done_unexpected cyc=%0d got=done expected=idle", cyc);
        end else begin
          e = sbq.pop_front();
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
          chk("err", 32'(err), 32'(e.err));
          chk("rd_data", 32'(rd_data), 32'(e.rd));
        end
      end else begin
        chk("err_without_done", 32'(err), 32'(0));
      end
    end
  end

  initial begin
    build_plan();
    // Reset asserted in the middle of a write strobe.
    RST = 1'b0;
    req_read = 1'b0; req_write = 1'b0; wr_data = 16'h1234; bus_in = 8'h00;
    data_ready = 1'b0; tbre = 1'b1; tsre = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1 req_write = 1'b1;
    @(posedge CLK);
    #1 req_write = 1'b0;
    @(posedge CLK);
    #1;
    chk("wr_low_before_reset", 32'(wrn), 32'(0));
    chk("bus_out_latched", 32'(bus_out), 32'(8'h34));
    #1 RST = 1'b0;
    #1;
    chk("rst_wrn", 32'(wrn), 32'(1));
    chk("rst_bus_oe", 32'(bus_oe), 32'(0));
    chk("rst_rdn", 32'(rdn), 32'(1));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_rd_data", 32'(rd_data), 32'(0));
    chk("rst_bus_out", 32'(bus_out), 32'(0));
    @(posedge CLK);
    #1 RST = 1'b1;
    cyc = 0;
    apply(0);
    run_mon = 1'b1;
    for (int c = 1; c <= end_cyc; c++) begin
      @(posedge CLK);
      #1;
      cyc = c;
      apply(c);
    end
    @(posedge CLK);
    run_mon = 1'b0;
    if (sbq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL done_never got_pending=%0d expected=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
